// File: rtl/mini_src_pkg.sv
// Shared opcode, ALU-select, state and instruction-class definitions for the
// Mini SRC hardwired control sequencer.
package mini_src_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        IC_RTYPE, IC_IMM, IC_LDI, IC_LD, IC_ST, IC_NOP, IC_HALT, IC_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the Mini SRC datapath (slave).
interface control_unit_if;
    logic [31:0] IR;
    logic        stop;
    logic        run;
    logic        illegal;
    logic        PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, In_out, C_out, R_out, BAout;
    logic        Gra, Grb, Grc, Rin;
    logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd;
    logic        IncPC, Read, Write;
    logic [4:0]  op_sel;

    modport master (
        input  IR, stop,
        output run, illegal,
        output PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, In_out, C_out, R_out, BAout,
        output Gra, Grb, Grc, Rin,
        output MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd,
        output IncPC, Read, Write, op_sel
    );

    modport slave (
        output IR, stop,
        input  run, illegal,
        input  PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, In_out, C_out, R_out, BAout,
        input  Gra, Grb, Grc, Rin,
        input  MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd,
        input  IncPC, Read, Write, op_sel
    );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode to instruction-class decode, plus the ALU select each class uses in T4.
module ctrl_decode
    import mini_src_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output iclass_t        iclass,
    output logic [4:0]     alu_sel
);

    always_comb begin
        iclass  = IC_ILLEGAL;
        alu_sel = '0;
        case (opcode) inside
            [OP_ADD:OP_SHL]: begin iclass = IC_RTYPE; alu_sel = opcode; end
            OP_ADDI:         begin iclass = IC_IMM;   alu_sel = ALU_ADD; end
            OP_ANDI:         begin iclass = IC_IMM;   alu_sel = ALU_AND; end
            OP_ORI:          begin iclass = IC_IMM;   alu_sel = ALU_OR;  end
            // Address generation for ldi/ld/st is an add of base and offset.
            OP_LDI:          begin iclass = IC_LDI;   alu_sel = ALU_ADD; end
            OP_LD:           begin iclass = IC_LD;    alu_sel = ALU_ADD; end
            OP_ST:           begin iclass = IC_ST;    alu_sel = ALU_ADD; end
            OP_NOP:          iclass = IC_NOP;
            OP_HALT:         iclass = IC_HALT;
            default:         iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: common T0-T2 fetch,
// per-class execute, then back to T0 (or HALT on stop/halt/illegal).
module control_unit
    import mini_src_pkg::*;
#(
    parameter int OPW             = 5,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master bus
);

    state_t     state_q, state_d, boundary;
    logic       illegal_q, illegal_d;
    iclass_t    iclass;
    logic [4:0] alu_sel;
    logic       unused_ir;

    assign unused_ir = ^bus.IR[31-OPW:0];

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode  (bus.IR[31:32-OPW]),
        .iclass  (iclass),
        .alu_sel (alu_sel)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // stop only matters where an instruction would otherwise return to T0.
    assign boundary = bus.stop ? S_HALT : S_T0;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2: begin
                case (iclass)
                    IC_NOP:  state_d = boundary;
                    IC_HALT: state_d = S_HALT;
                    IC_ILLEGAL: begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? S_HALT : boundary;
                    end
                    default: state_d = S_T3;
                endcase
            end
            S_T3:   state_d = S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (iclass == IC_LD || iclass == IC_ST) ? S_T6 : boundary;
            S_T6:   state_d = S_T7;
            S_T7:   state_d = boundary;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.PC_out  = 1'b0; bus.MDR_out = 1'b0; bus.Zlo_out = 1'b0; bus.Zhi_out = 1'b0;
        bus.HI_out  = 1'b0; bus.LO_out  = 1'b0; bus.In_out  = 1'b0; bus.C_out   = 1'b0;
        bus.R_out   = 1'b0; bus.BAout   = 1'b0;
        bus.Gra     = 1'b0; bus.Grb     = 1'b0; bus.Grc     = 1'b0; bus.Rin     = 1'b0;
        bus.MAR_rd  = 1'b0; bus.Zlo_rd  = 1'b0; bus.PC_rd   = 1'b0; bus.MDR_rd  = 1'b0;
        bus.IR_rd   = 1'b0; bus.Y_rd    = 1'b0;
        bus.IncPC   = 1'b0; bus.Read    = 1'b0; bus.Write   = 1'b0;
        bus.op_sel  = '0;
        bus.run     = (state_q != S_IDLE) && (state_q != S_HALT);
        bus.illegal = illegal_q;
        case (state_q)
            S_T0: begin bus.PC_out = 1'b1; bus.MAR_rd = 1'b1; bus.IncPC = 1'b1; bus.Zlo_rd = 1'b1; end
            S_T1: begin bus.Zlo_out = 1'b1; bus.PC_rd = 1'b1; bus.Read = 1'b1; bus.MDR_rd = 1'b1; end
            S_T2: begin bus.MDR_out = 1'b1; bus.IR_rd = 1'b1; end
            S_T3: begin
                bus.Grb  = 1'b1;
                bus.Y_rd = 1'b1;
                if (iclass == IC_RTYPE || iclass == IC_IMM) bus.R_out = 1'b1;
                else                                        bus.BAout = 1'b1;
            end
            S_T4: begin
                bus.Zlo_rd = 1'b1;
                bus.op_sel = alu_sel;
                if (iclass == IC_RTYPE) begin bus.Grc = 1'b1; bus.R_out = 1'b1; end
                else                    bus.C_out = 1'b1;
            end
            S_T5: begin
                bus.Zlo_out = 1'b1;
                if (iclass == IC_LD || iclass == IC_ST) bus.MAR_rd = 1'b1;
                else begin bus.Gra = 1'b1; bus.Rin = 1'b1; end
            end
            S_T6: begin
                // A store loads MDR from the register on the bus, not from memory.
                bus.MDR_rd = 1'b1;
                if (iclass == IC_ST) begin bus.Gra = 1'b1; bus.R_out = 1'b1; end
                else                 bus.Read = 1'b1;
            end
            S_T7: begin
                if (iclass == IC_ST) bus.Write = 1'b1;
                else begin bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction micro-step tables as reference model,
// directed literal sequences, then randomized instruction streams.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        stop;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    control_unit_if bus1 ();
    control_unit_if bus0 ();
    assign bus1.IR = ir;  assign bus1.stop = stop;
    assign bus0.IR = ir;  assign bus0.stop = stop;

    control_unit #(.OPW(5), .HALT_ON_ILLEGAL(1'b1)) dut1 (.clk(clk), .clr(clr), .bus(bus1));
    control_unit #(.OPW(5), .HALT_ON_ILLEGAL(1'b0)) dut0 (.clk(clk), .clr(clr), .bus(bus0));

    logic [31:0] act1, act0;
    assign act1 = {3'b0, bus1.op_sel, bus1.run, bus1.Write, bus1.Read, bus1.IncPC, bus1.Y_rd,
                   bus1.IR_rd, bus1.MDR_rd, bus1.PC_rd, bus1.Zlo_rd, bus1.MAR_rd, bus1.Rin,
                   bus1.Grc, bus1.Grb, bus1.Gra, bus1.BAout, bus1.R_out, bus1.C_out,
                   bus1.In_out, bus1.LO_out, bus1.HI_out, bus1.Zhi_out, bus1.Zlo_out,
                   bus1.MDR_out, bus1.PC_out};
    assign act0 = {3'b0, bus0.op_sel, bus0.run, bus0.Write, bus0.Read, bus0.IncPC, bus0.Y_rd,
                   bus0.IR_rd, bus0.MDR_rd, bus0.PC_rd, bus0.Zlo_rd, bus0.MAR_rd, bus0.Rin,
                   bus0.Grc, bus0.Grb, bus0.Gra, bus0.BAout, bus0.R_out, bus0.C_out,
                   bus0.In_out, bus0.LO_out, bus0.HI_out, bus0.Zhi_out, bus0.Zlo_out,
                   bus0.MDR_out, bus0.PC_out};

    localparam logic [31:0] PC_O   = 32'h1,     MDR_O  = 32'h2,     ZLO_O  = 32'h4;
    localparam logic [31:0] C_O    = 32'h80,    R_O    = 32'h100,   BA_O   = 32'h200;
    localparam logic [31:0] GRA    = 32'h400,   GRB    = 32'h800,   GRC    = 32'h1000;
    localparam logic [31:0] RIN    = 32'h2000,  MAR_RD = 32'h4000,  ZLO_RD = 32'h8000;
    localparam logic [31:0] PC_RD  = 32'h10000, MDR_RD = 32'h20000, IR_RD  = 32'h40000;
    localparam logic [31:0] Y_RD   = 32'h80000, INCPC  = 32'h100000, READ  = 32'h200000;
    localparam logic [31:0] WRITE  = 32'h400000, RUN   = 32'h800000;

    function automatic logic [31:0] opv(input logic [4:0] x);
        return {3'b0, x, 24'd0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    // Model: 0 = idle, 1 = running an instruction, 2 = halted.
    int          m_mode [2];
    int          m_idx  [2];
    int          m_len  [2];
    logic [31:0] m_seq  [2][8];
    logic        m_ill  [2];

    task automatic m_push(input int k, input logic [31:0] v);
        m_seq[k][m_len[k]] = v;
        m_len[k]++;
    endtask

    task automatic m_start(input int k);
        m_mode[k] = 1; m_idx[k] = 0; m_len[k] = 0;
        m_push(k, PC_O | MAR_RD | INCPC | ZLO_RD);
        m_push(k, ZLO_O | PC_RD | READ | MDR_RD);
        m_push(k, MDR_O | IR_RD);
    endtask

    task automatic m_exec(input int k, input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) begin
            m_push(k, GRB | R_O | Y_RD);
            m_push(k, GRC | R_O | ZLO_RD | opv(op));
            m_push(k, ZLO_O | GRA | RIN);
        end else if (op >= 5'd12 && op <= 5'd14) begin
            m_push(k, GRB | R_O | Y_RD);
            m_push(k, C_O | ZLO_RD | opv(op == 5'd12 ? 5'd3 : (op == 5'd13 ? 5'd5 : 5'd6)));
            m_push(k, ZLO_O | GRA | RIN);
        end else if (op <= 5'd2) begin
            m_push(k, GRB | BA_O | Y_RD);
            m_push(k, C_O | ZLO_RD | opv(5'd3));
            if (op == 5'd1) m_push(k, ZLO_O | GRA | RIN);
            else begin
                m_push(k, ZLO_O | MAR_RD);
                if (op == 5'd0) begin
                    m_push(k, READ | MDR_RD);
                    m_push(k, MDR_O | GRA | RIN);
                end else begin
                    m_push(k, GRA | R_O | MDR_RD);
                    m_push(k, WRITE);
                end
            end
        end else if (op == 5'd26) begin
        end else if (op == 5'd27) begin
            m_mode[k] = 2;
        end else begin
            m_ill[k] = 1'b1;
            if (k == 1) m_mode[k] = 2;
        end
    endtask

    task automatic m_step(input int k);
        if (!clr) begin
            m_mode[k] = 0; m_ill[k] = 1'b0;
            return;
        end
        if (m_mode[k] == 0) m_start(k);
        else if (m_mode[k] == 1) begin
            m_idx[k]++;
            if (m_idx[k] == 3) m_exec(k, ir[31:27]);
            if (m_mode[k] == 1 && m_idx[k] == m_len[k]) begin
                if (stop) m_mode[k] = 2;
                else      m_start(k);
            end
        end
    endtask

    function automatic logic [31:0] m_exp(input int k);
        return (m_mode[k] == 1) ? (m_seq[k][m_idx[k]] | RUN) : 32'd0;
    endfunction

    function automatic bit safe(input int k);
        return (m_mode[k] != 1) || (m_idx[k] == 0);
    endfunction

    always @(posedge clk) begin
        m_step(0);
        m_step(1);
        #1;
        chk("model_vec_h1", act1, m_exp(1));
        chk("model_ill_h1", {31'd0, bus1.illegal}, {31'd0, m_ill[1]});
        chk("model_vec_h0", act0, m_exp(0));
        chk("model_ill_h0", {31'd0, bus0.illegal}, {31'd0, m_ill[0]});
    end

    task automatic step_chk(input string nm, input logic [31:0] e);
        @(negedge clk);
        chk(nm, act1, e);
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] op;
        int u;
        u = $urandom_range(0, 9);
        if (u < 7)       op = 5'($urandom_range(0, 14));
        else if (u == 7) op = 5'd26;
        else if (u == 8) op = 5'd27;
        else             op = 5'($urandom_range(0, 31));
        return {op, 27'($urandom)};
    endfunction

    initial begin
        clr = 1'b0; stop = 1'b0; ir = 32'h6AB00095;
        @(negedge clk); @(negedge clk);
        chk("reset_vec", act1, 32'd0);
        chk("reset_ill", {31'd0, bus1.illegal}, 32'd0);
        clr = 1'b1;
        step_chk("andi_T0", 32'h0090C001);
        step_chk("andi_T1", 32'h00A30004);
        step_chk("andi_T2", 32'h00840002);
        step_chk("andi_T3", 32'h00880900);
        step_chk("andi_T4", 32'h05808080);
        step_chk("andi_T5", 32'h00802404);
        step_chk("andi_next_T0", 32'h0090C001);
        ir = 32'hD8000000;
        step_chk("halt_T1", 32'h00A30004);
        step_chk("halt_T2", 32'h00840002);
        step_chk("halt_state", 32'd0);
        repeat (10) @(negedge clk);
        chk("halt_hold", act1, 32'd0);

        clr = 1'b0; ir = 32'hF8000000;
        @(negedge clk); clr = 1'b1;
        step_chk("ill_T0", 32'h0090C001);
        step_chk("ill_T1", 32'h00A30004);
        step_chk("ill_T2", 32'h00840002);
        @(negedge clk);
        chk("ill_halt_vec", act1, 32'd0);
        chk("ill_flag_h1", {31'd0, bus1.illegal}, 32'd1);
        chk("ill_flag_h0", {31'd0, bus0.illegal}, 32'd1);
        chk("ill_cont_T0", act0, 32'h0090C001);

        clr = 1'b0; ir = 32'h18918000;
        @(negedge clk); clr = 1'b1;
        step_chk("add_T0", 32'h0090C001);
        step_chk("add_T1", 32'h00A30004);
        step_chk("add_T2", 32'h00840002);
        step_chk("add_T3", 32'h00880900);
        stop = 1'b1;
        step_chk("stop_T4", 32'h03809100);
        step_chk("stop_T5", 32'h00802404);
        step_chk("stop_halt", 32'd0);
        stop = 1'b0;

        clr = 1'b0; ir = 32'h00800010;
        @(negedge clk); clr = 1'b1;
        step_chk("ld_T0", 32'h0090C001);
        step_chk("ld_T1", 32'h00A30004);
        step_chk("ld_T2", 32'h00840002);
        step_chk("ld_T3", 32'h00880A00);
        step_chk("ld_T4", 32'h03808080);
        #1 clr = 1'b0;
        #1 chk("abort_vec", act1, 32'd0);
        @(negedge clk); clr = 1'b1;
        step_chk("re_T0", 32'h0090C001);
        step_chk("re_T1", 32'h00A30004);
        step_chk("re_T2", 32'h00840002);
        step_chk("re_T3", 32'h00880A00);
        step_chk("re_T4", 32'h03808080);
        step_chk("ld_T5", 32'h00804004);
        step_chk("ld_T6", 32'h00A20000);
        step_chk("ld_T7", 32'h00802402);
        step_chk("ld_next_T0", 32'h0090C001);
        ir = 32'h10800010;
        step_chk("st_T1", 32'h00A30004);
        step_chk("st_T2", 32'h00840002);
        step_chk("st_T3", 32'h00880A00);
        step_chk("st_T4", 32'h03808080);
        step_chk("st_T5", 32'h00804004);
        step_chk("st_T6", 32'h00820500);
        step_chk("st_T7", 32'h00C00000);
        step_chk("st_next_T0", 32'h0090C001);
        ir = 32'hD0000000;
        step_chk("nop_T1", 32'h00A30004);
        step_chk("nop_T2", 32'h00840002);
        step_chk("nop_next_T0", 32'h0090C001);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!clr) clr = 1'b1;
            else if (m_mode[1] == 2 || $urandom_range(0, 299) == 0) begin
                clr = 1'b0;
                #1;
                chk("rand_clr_h1", act1, 32'd0);
                chk("rand_clr_h0", act0, 32'd0);
            end
            if (safe(0) && safe(1)) ir = rand_ir();
            stop = ($urandom_range(0, 15) == 0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
